// File: rtl/clock_pkg.sv
// Shared FSM state encoding and BCD digit limits for the time-of-day register.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  // Seconds and minutes share limits: tens 0..5, ones 0..9
  localparam logic [2:0] MS_TENS_MAX  = 3'd5;
  localparam logic [3:0] ONES_MAX     = 4'd9;

  localparam logic [1:0] H24_TENS_MAX = 2'd2;
  localparam logic [3:0] H24_ONES_MAX = 4'd3;

  localparam logic [1:0] H12_TENS_MIN = 2'd0;
  localparam logic [3:0] H12_ONES_MIN = 4'd1;
  localparam logic [1:0] H12_TENS_MAX = 2'd1;
  localparam logic [3:0] H12_ONES_MAX = 4'd2;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for a slow asynchronous level; with EDGE set the output
// is a one-cycle strobe on each synchronised rising edge instead of the level.
module sync_edge #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], d};
  end

  generate
    if (EDGE) begin : g_edge
      logic       prev;
      logic [2:0] vld_pipe;

      // Strobes are held off until the whole pipe holds post-reset samples,
      // so a level already high at reset release is not mistaken for an edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev     <= 1'b0;
          vld_pipe <= 3'b000;
        end else begin
          prev     <= sync[1];
          vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
      end

      assign q = sync[1] & ~prev & vld_pipe[2];
    end else begin : g_level
      assign q = sync[1];
    end
  endgenerate

endmodule

// File: rtl/clock_register.sv
// Time-of-day register: BCD hh:mm:ss with run / set-hours / set-minutes modes,
// 24-hour or 12-hour (with PM flag) counting chosen at elaboration.
module clock_register
  import clock_pkg::*;
#(
  parameter bit MODE_12H = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_1hz,
  input  logic       i_set,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic [1:0] o_hours_tens,
  output logic [3:0] o_hours_ones,
  output logic [2:0] o_minutes_tens,
  output logic [3:0] o_minutes_ones,
  output logic [2:0] o_seconds_tens,
  output logic [3:0] o_seconds_ones,
  output logic       o_pm,
  output logic       o_setting
);

  localparam logic [1:0] H_RST_TENS = MODE_12H ? 2'd1 : 2'd0;
  localparam logic [3:0] H_RST_ONES = MODE_12H ? 4'd2 : 4'd0;

  logic tick_sec, tick_set, set_h, set_m;

  sync_edge #(.EDGE(1'b1)) u_sync_1hz (.clk(clk), .rst_n(rst_n), .d(i_1hz),         .q(tick_sec));
  sync_edge #(.EDGE(1'b1)) u_sync_set (.clk(clk), .rst_n(rst_n), .d(i_set),         .q(tick_set));
  sync_edge #(.EDGE(1'b0)) u_sync_h   (.clk(clk), .rst_n(rst_n), .d(i_set_hours),   .q(set_h));
  sync_edge #(.EDGE(1'b0)) u_sync_m   (.clk(clk), .rst_n(rst_n), .d(i_set_minutes), .q(set_m));

  state_t state, state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (set_h)               state_nx = SET_H;
               else if (set_m)          state_nx = SET_M;
      SET_H:   if (!set_h && !set_m)    state_nx = RUN;
               else if (!set_h)         state_nx = SET_M;
      SET_M:   if (!set_h && !set_m)    state_nx = RUN;
               else if (set_h)          state_nx = SET_H;
      default:                          state_nx = RUN;
    endcase
  end

  // Per-field increment candidates
  logic       s_ones_wrap, s_wrap, m_ones_wrap, m_wrap, pm_flip;
  logic [2:0] st_inc, mt_inc;
  logic [3:0] so_inc, mo_inc, ho_inc;
  logic [1:0] ht_inc;

  assign s_ones_wrap = (o_seconds_ones == ONES_MAX);
  assign s_wrap      = s_ones_wrap && (o_seconds_tens == MS_TENS_MAX);
  assign so_inc      = s_ones_wrap ? 4'd0 : o_seconds_ones + 4'd1;
  assign st_inc      = s_ones_wrap ? (s_wrap ? 3'd0 : o_seconds_tens + 3'd1) : o_seconds_tens;

  assign m_ones_wrap = (o_minutes_ones == ONES_MAX);
  assign m_wrap      = m_ones_wrap && (o_minutes_tens == MS_TENS_MAX);
  assign mo_inc      = m_ones_wrap ? 4'd0 : o_minutes_ones + 4'd1;
  assign mt_inc      = m_ones_wrap ? (m_wrap ? 3'd0 : o_minutes_tens + 3'd1) : o_minutes_tens;

  always_comb begin
    ht_inc  = o_hours_tens;
    ho_inc  = o_hours_ones + 4'd1;
    pm_flip = 1'b0;
    if (MODE_12H) begin
      if (o_hours_tens == H12_TENS_MAX && o_hours_ones == H12_ONES_MAX) begin
        ht_inc = H12_TENS_MIN;
        ho_inc = H12_ONES_MIN;
      end else begin
        // 11 -> 12 is where AM/PM changes in 12-hour counting
        pm_flip = (o_hours_tens == H12_TENS_MAX) && (o_hours_ones == H12_ONES_MAX - 4'd1);
        if (o_hours_ones == ONES_MAX) begin
          ht_inc = o_hours_tens + 2'd1;
          ho_inc = 4'd0;
        end
      end
    end else begin
      if (o_hours_tens == H24_TENS_MAX && o_hours_ones == H24_ONES_MAX) begin
        ht_inc = 2'd0;
        ho_inc = 4'd0;
      end else if (o_hours_ones == ONES_MAX) begin
        ht_inc = o_hours_tens + 2'd1;
        ho_inc = 4'd0;
      end
    end
  end

  logic [1:0] ht_nx;
  logic [3:0] ho_nx, mo_nx, so_nx;
  logic [2:0] mt_nx, st_nx;
  logic       pm_nx;

  always_comb begin
    ht_nx = o_hours_tens;
    ho_nx = o_hours_ones;
    mt_nx = o_minutes_tens;
    mo_nx = o_minutes_ones;
    st_nx = o_seconds_tens;
    so_nx = o_seconds_ones;
    pm_nx = o_pm;
    unique case (state)
      RUN: if (tick_sec) begin
        st_nx = st_inc;
        so_nx = so_inc;
        if (s_wrap) begin
          mt_nx = mt_inc;
          mo_nx = mo_inc;
          if (m_wrap) begin
            ht_nx = ht_inc;
            ho_nx = ho_inc;
            pm_nx = o_pm ^ pm_flip;
          end
        end
      end
      SET_H: begin
        st_nx = 3'd0;
        so_nx = 4'd0;
        if (tick_set) begin
          ht_nx = ht_inc;
          ho_nx = ho_inc;
          pm_nx = o_pm ^ pm_flip;
        end
      end
      SET_M: begin
        st_nx = 3'd0;
        so_nx = 4'd0;
        if (tick_set) begin
          mt_nx = mt_inc;
          mo_nx = mo_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      o_setting      <= 1'b0;
      o_hours_tens   <= H_RST_TENS;
      o_hours_ones   <= H_RST_ONES;
      o_minutes_tens <= 3'd0;
      o_minutes_ones <= 4'd0;
      o_seconds_tens <= 3'd0;
      o_seconds_ones <= 4'd0;
      o_pm           <= 1'b0;
    end else begin
      state          <= state_nx;
      o_setting      <= (state != RUN);
      o_hours_tens   <= ht_nx;
      o_hours_ones   <= ho_nx;
      o_minutes_tens <= mt_nx;
      o_minutes_ones <= mo_nx;
      o_seconds_tens <= st_nx;
      o_seconds_ones <= so_nx;
      o_pm           <= pm_nx;
    end
  end

endmodule

// File: tb/tb_clock_register.sv
// Drives a 24-hour and a 12-hour clock_register with the same inputs and checks
// both against one time-of-day model kept as plain integer hours/minutes/seconds.
module tb_clock_register;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_1hz = 1'b0, i_set = 1'b0, i_set_hours = 1'b0, i_set_minutes = 1'b0;

  logic [1:0] a_ht, b_ht;
  logic [3:0] a_ho, b_ho, a_mo, b_mo, a_so, b_so;
  logic [2:0] a_mt, b_mt, a_st, b_st;
  logic       a_pm, b_pm, a_set, b_set;

  always #5 clk = ~clk;

  clock_register #(.MODE_12H(1'b0)) dut24 (
    .clk(clk), .rst_n(rst_n), .i_1hz(i_1hz), .i_set(i_set),
    .i_set_hours(i_set_hours), .i_set_minutes(i_set_minutes),
    .o_hours_tens(a_ht), .o_hours_ones(a_ho), .o_minutes_tens(a_mt),
    .o_minutes_ones(a_mo), .o_seconds_tens(a_st), .o_seconds_ones(a_so),
    .o_pm(a_pm), .o_setting(a_set));

  clock_register #(.MODE_12H(1'b1)) dut12 (
    .clk(clk), .rst_n(rst_n), .i_1hz(i_1hz), .i_set(i_set),
    .i_set_hours(i_set_hours), .i_set_minutes(i_set_minutes),
    .o_hours_tens(b_ht), .o_hours_ones(b_ho), .o_minutes_tens(b_mt),
    .o_minutes_ones(b_mo), .o_seconds_tens(b_st), .o_seconds_ones(b_so),
    .o_pm(b_pm), .o_setting(b_set));

  logic [21:0] obs24, obs12;
  assign obs24 = {a_ht, a_ho, a_mt, a_mo, a_st, a_so, a_pm, a_set};
  assign obs12 = {b_ht, b_ho, b_mt, b_mo, b_st, b_so, b_pm, b_set};

  int checks = 0, errors = 0;

  // Model: time as 24-hour integers; mode 0 run, 1 setting hours, 2 setting minutes
  int mh = 0, mm = 0, ms = 0, mst = 0;

  function automatic logic [21:0] exp_vec(input bit m12);
    int  hd;
    logic pm;
    hd = mh;
    pm = 1'b0;
    if (m12) begin
      pm = (mh >= 12);
      hd = (mh % 12 == 0) ? 12 : mh % 12;
    end
    return {2'(hd / 10), 4'(hd % 10), 3'(mm / 10), 4'(mm % 10),
            3'(ms / 10), 4'(ms % 10), pm, (mst != 0)};
  endfunction

  task automatic check(input string tag);
    logic [21:0] e24, e12;
    e24 = exp_vec(1'b0);
    e12 = exp_vec(1'b1);
    checks++;
    assert (obs24 === e24) else begin
      errors++;
      $error("FAIL %s 24h observed=%h expected=%h", tag, obs24, e24);
    end
    checks++;
    assert (obs12 === e12) else begin
      errors++;
      $error("FAIL %s 12h observed=%h expected=%h", tag, obs12, e12);
    end
  endtask

  task automatic m_reset();
    mh = 0; mm = 0; ms = 0; mst = 0;
  endtask

  task automatic m_tick_sec();
    if (mst == 0) begin
      ms++;
      if (ms == 60) begin
        ms = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          mh = (mh + 1) % 24;
        end
      end
    end
  endtask

  task automatic m_tick_set();
    if (mst == 1)      mh = (mh + 1) % 24;
    else if (mst == 2) mm = (mm + 1) % 60;
  endtask

  task automatic m_buttons(input bit sh, input bit sm);
    if (!sh && !sm)            mst = 0;
    else if (mst == 0)         mst = sh ? 1 : 2;
    else if (mst == 1 && !sh)  mst = 2;
    else if (mst == 2 && sh)   mst = 1;
    if (mst != 0) ms = 0;
  endtask

  // All driving happens 1 time unit after a rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_1hz(input int n);
    for (int i = 0; i < n; i++) begin
      i_1hz = 1'b1; cyc($urandom_range(3, 5));
      i_1hz = 1'b0; cyc($urandom_range(3, 5));
      m_tick_sec();
    end
  endtask

  task automatic pulse_set(input int n);
    for (int i = 0; i < n; i++) begin
      i_set = 1'b1; cyc($urandom_range(3, 5));
      i_set = 1'b0; cyc($urandom_range(3, 5));
      m_tick_set();
    end
  endtask

  task automatic buttons(input bit sh, input bit sm);
    i_set_hours = sh;
    i_set_minutes = sm;
    cyc(6);
    m_buttons(sh, sm);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    cyc(3);
    m_reset();
    check("reset_held");
    rst_n = 1'b1;
    cyc(4);
    check("reset_released");

    pulse_1hz(60);
    check("sixty_seconds");

    // 24h wrap via preload to 23:59
    buttons(1'b1, 1'b0);
    pulse_set(23);
    check("set_hours_23");
    buttons(1'b0, 1'b1);
    pulse_set(59 - mm);
    check("set_minutes_59");
    buttons(1'b0, 1'b0);
    pulse_1hz(60);
    check("midnight_wrap");

    // 11:59:59 -> noon, then 12:59:59 -> 1 o'clock
    buttons(1'b1, 1'b0);
    pulse_set(11);
    buttons(1'b0, 1'b1);
    pulse_set(59);
    buttons(1'b0, 1'b0);
    pulse_1hz(59);
    check("before_noon");
    pulse_1hz(1);
    check("noon");
    buttons(1'b0, 1'b1);
    pulse_set(59);
    buttons(1'b0, 1'b0);
    pulse_1hz(59);
    check("before_one");
    pulse_1hz(1);
    check("one_pm");

    // Minutes hold: wrap without carry, seconds frozen at 00
    buttons(1'b0, 1'b1);
    pulse_set(61);
    pulse_1hz(3);
    check("minutes_hold");
    buttons(1'b1, 1'b1);
    pulse_set(3);
    check("both_pressed");
    buttons(1'b0, 1'b1);
    pulse_set(2);
    check("hours_released");
    buttons(1'b0, 1'b0);
    check("back_to_run");

    // Edge-to-update latency: first sample at edge N, update at N+2
    pulse_1hz(5);
    i_1hz = 1'b1;
    cyc(1);
    check("latency_n");
    cyc(1);
    check("latency_n1");
    cyc(1);
    m_tick_sec();
    check("latency_n2");
    i_1hz = 1'b0;
    cyc(4);

    // Randomised mix of run pulses, set pulses and button changes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       pulse_1hz($urandom_range(1, 40));
        1:       buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: pulse_set($urandom_range(1, 30));
      endcase
      check("random_mix");
    end
    buttons(1'b0, 1'b0);

    // Level high through reset release must not count
    i_1hz = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    m_reset();
    rst_n = 1'b1;
    cyc(10);
    check("held_through_reset");
    i_1hz = 1'b0;
    cyc(4);

    // Asynchronous reset from 05:42:17
    buttons(1'b1, 1'b0);
    pulse_set(5);
    buttons(1'b0, 1'b1);
    pulse_set(42);
    buttons(1'b0, 1'b0);
    pulse_1hz(17);
    check("at_05_42_17");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    check("async_reset");
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_register.md
# clock_register

Time-of-day register for the digital clock: consumes the 1 Hz and 5 Hz set-rate signals produced by the clock divider plus the two user set buttons, and maintains hours/minutes/seconds as BCD digits for the display driver downstream. All logic runs on the single system clock; divider outputs and buttons are treated as slow asynchronous levels, synchronised and edge-detected internally. Supports 24-hour or 12-hour (with PM flag) counting, selected at elaboration.

## Interface
- MODE_12H, 0, 1 selects 12-hour counting (01..12 plus PM flag); 0 selects 24-hour counting (00..23).
- clk  input  1  system clock (12.5 kHz in the clock design).
- rst_n  input  1  asynchronous, active-low reset.
- i_1hz  input  1  1 Hz level from the divider; each rising edge advances time by one second.
- i_set  input  1  set-rate level (~5 Hz) from the divider; each rising edge advances the digit being set.
- i_set_hours  input  1  button level, high = set hours.
- i_set_minutes  input  1  button level, high = set minutes.
- o_hours_tens  output  2  BCD hours tens.
- o_hours_ones  output  4  BCD hours ones.
- o_minutes_tens  output  3  BCD minutes tens.
- o_minutes_ones  output  4  BCD minutes ones.
- o_seconds_tens  output  3  BCD seconds tens.
- o_seconds_ones  output  4  BCD seconds ones.
- o_pm  output  1  PM flag; constant 0 when MODE_12H = 0.
- o_setting  output  1  high while in a set state.

## Operation
- Four inputs each pass through a 2-flop synchroniser; i_1hz and i_set additionally get a rising-edge detector producing one-cycle strobes tick_sec and tick_set.
- States: RUN, SET_H, SET_M. Reset state RUN.
- RUN: tick_sec increments seconds; 59→00 carries into minutes; minutes 59→00 carries into hours. tick_set ignored.
- RUN→SET_H when synced i_set_hours = 1; RUN→SET_M when synced i_set_minutes = 1 and i_set_hours = 0. Hours has priority when both pressed.
- SET_H: each tick_set increments hours only (wrap per mode, no carry elsewhere). SET_M: each tick_set increments minutes only, 59→00 without carry into hours. In both set states seconds are forced to 00 and tick_sec is ignored.
- SET_H→SET_M if i_set_hours falls while i_set_minutes is high; SET_M→SET_H if i_set_hours rises. Any set state→RUN when both buttons are low.
- 24-hour wrap: 23:59:59 → 00:00:00. 12-hour wrap: 12:59:59 → 01:00:00; 11:59:59 → 12:00:00 toggles o_pm. In SET_H with MODE_12H, 11→12 toggles o_pm and 12→01 does not.
- All digits are always valid BCD; no illegal value is reachable from reset.

## Timing
- Reset: all outputs 0 except, with MODE_12H = 1, o_hours_tens = 1 and o_hours_ones = 2 (12:00:00 AM). State RUN, synchroniser and edge flops cleared (so an input held high through reset produces no strobe).
- Latency: if i_1hz is first sampled high at clk edge N, the seconds digits change at edge N+2. Same for i_set → set increment.
- Full carry chain (seconds, minutes, hours, PM) resolves in the single update cycle; all outputs are registered and change on the same edge.
- Button state change is seen by the FSM 2 cycles after first sample; o_setting follows on the next edge.
- tick_sec coinciding with the RUN→SET transition cycle is applied (state was RUN); tick_set on that cycle is ignored.
- Reset mid-operation returns immediately (asynchronously) to reset values.

## Structure
- Package clock_pkg: state encoding (RUN, SET_H, SET_M) and BCD limit constants (seconds/minutes max 5/9, hours 24h max 2/3, 12h min 0/1 and max 1/2).
- One sub-module sync_edge: 2-flop synchroniser with optional rising-edge strobe output; instantiated four times.
- Digit increment and wrap logic lives inline in clock_register.

## Test plan
- Reset with MODE_12H = 0, 60 i_1hz pulses → 00:01:00; 24h preload path: set to 23:59 via buttons, then 60 pulses → 00:00:00.
- MODE_12H = 1 from reset, set hours to 11, run to 11:59:59 then one i_1hz edge → 12:00:00, o_pm = 1; continue to 12:59:59 → 01:00:00, o_pm unchanged.
- Hold i_set_minutes, 61 i_set edges from 00 → minutes 01, hours unchanged, seconds 00, o_setting = 1; i_1hz edges during hold do not change seconds.
- Press both buttons → only hours increment per i_set edge; release hours while minutes held → minutes now increment.
- i_1hz rising at edge N → seconds change exactly at edge N+2; i_1hz held high across rst_n deassertion → no increment.
- Assert rst_n low mid-count at 05:42:17 → outputs clear asynchronously to reset values.
